ahb_lite_master: RTL

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

---
 rtl/ahb_pkg.sv | 47 ++++
 rtl/ahb_wait_timer.sv | 41 ++++
 rtl/ahb_lite_master.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite master package: bus encodings, FSM states, wait-timeout limit
// and the request legality check shared by the master and its helpers.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR
    } state_e;

    localparam int unsigned TIMEOUT_LIMIT = 16;

    // A request may go on the bus only if its size is byte/half/word and
    // the address is naturally aligned to that size.
    function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lo[0];
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_wait_timer.sv
// Counts consecutive stalled cycles and flags the cycle on which the
// count reaches LIMIT. Only instantiated when AHB_MASTER_TIMEOUT_EN is set.
module ahb_wait_timer
    import ahb_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_LIMIT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic count_en_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise advance while stalled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the LIMIT-th consecutive stalled cycle.
    assign expired_o = count_en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite master with one outstanding request.
// Optional feature: define AHB_MASTER_TIMEOUT_EN to abort a transfer after
// TIMEOUT_LIMIT consecutive HREADY-low cycles.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [2:0]        HBURST,
    output logic              HMASTLOCK,
    output logic [3:0]        HPROT,
    output logic [2:0]        HSIZE,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    state_e            state_q, state_d;
    htrans_e           htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              timeout_hit;

`ifdef AHB_MASTER_TIMEOUT_EN
    logic busy;
    logic timer_clear;

    assign busy        = (state_q != ST_IDLE);
    assign timer_clear = HREADY || (state_d != state_q);

    ahb_wait_timer #(
        .LIMIT(TIMEOUT_LIMIT)
    ) u_wait_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .count_en_i (busy && !HREADY),
        .clear_i    (timer_clear),
        .expired_o  (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and registered-output decode for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_legal(cmd_size, cmd_addr[1:0])) begin
                        state_d  = ST_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = cmd_addr;
                        hwrite_d = cmd_write;
                        hsize_d  = cmd_size;
                        wdata_d  = cmd_wdata;
                    end else begin
                        // Rejected locally: bus untouched, error response next cycle.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d  = ST_DATA;
                    htrans_d = HTRANS_IDLE;
                    if (hwrite_q) begin
                        hwdata_d = wdata_q;
                    end
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    if (HRESP) begin
                        rsp_err_d = 1'b1;
                    end else if (!hwrite_q) begin
                        rsp_rdata_d = HRDATA;
                    end
                end else if (HRESP) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (HREADY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase

        if (timeout_hit) begin
            state_d     = ST_IDLE;
            htrans_d    = HTRANS_IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign HADDR     = haddr_q;
    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_DEFAULT;
    assign HSIZE     = hsize_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;

endmodule
